// File: rtl/tft_timing_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : tft_timing_ctrl_if
// Description : Bundle of the run-control, pixel-clock-generator and panel
//               timing signals of tft_timing_ctrl.
//               master : system side that requests the display and owns the
//                        pixel-clock generator (drives enable, div_in, div_wr,
//                        pclk, lock; observes everything else).
//               slave  : the timing controller itself.
// Ports       : none (signal bundle only)
//   enable       display run request
//   div_in       requested pixel-clock divide value (16b)
//   div_wr       one-cycle strobe capturing div_in
//   pclk         pixel clock from the generator, synchronous to clk
//   lock         generator locked
//   gen_rst      reset to the pixel-clock generator
//   clock_divide divide value driven to the generator (16b)
//   disp_on      panel power / display enable
//   hsync/vsync  active-low syncs
//   de           data enable
//   x/y          active pixel column / line (11b)
//   frame_start  one-clk pulse at counter origin
//   lock_err     sticky lock-loss flag
// Revision    : 1.0 - initial release
// ============================================================================
interface tft_timing_ctrl_if;
    logic        enable;
    logic [15:0] div_in;
    logic        div_wr;
    logic        pclk;
    logic        lock;
    logic        gen_rst;
    logic [15:0] clock_divide;
    logic        disp_on;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [10:0] x;
    logic [10:0] y;
    logic        frame_start;
    logic        lock_err;

    modport master (
        output enable, div_in, div_wr, pclk, lock,
        input  gen_rst, clock_divide, disp_on, hsync, vsync, de, x, y,
               frame_start, lock_err
    );

    modport slave (
        input  enable, div_in, div_wr, pclk, lock,
        output gen_rst, clock_divide, disp_on, hsync, vsync, de, x, y,
               frame_start, lock_err
    );
endinterface
`default_nettype wire

// File: rtl/tft_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tft_timing_ctrl
// Description : TFT panel timing controller. Sequences the pixel-clock
//               generator and panel power (IDLE -> WAIT_LOCK -> POWER_UP ->
//               RUN -> POWER_DOWN), generates hsync/vsync/de and the active
//               pixel coordinates from h/v counters that advance on rising
//               edges of pclk, and applies pixel-clock divide changes only on
//               frame boundaries while the panel is being driven.
// Ports       :
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   bus   slave modport of tft_timing_ctrl_if (control, generator, timing)
// Revision    : 1.0 - initial release
// ============================================================================
module tft_timing_ctrl #(
    parameter int H_SYNC    = 41,
    parameter int H_BP      = 2,
    parameter int H_ACTIVE  = 480,
    parameter int H_FP      = 2,
    parameter int V_SYNC    = 10,
    parameter int V_BP      = 2,
    parameter int V_ACTIVE  = 272,
    parameter int V_FP      = 2,
    parameter int PWR_DELAY = 1000
) (
    input  wire logic       clk,
    input  wire logic       rst,
    tft_timing_ctrl_if.slave bus
);

    // ------------------------------------------------------------------------
    // Derived constants. Window bounds are 12 bits wide because an end bound
    // may equal 2048 when the matching porch is zero.
    // ------------------------------------------------------------------------
    localparam int          C_H_TOTAL    = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int          C_V_TOTAL    = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam logic [10:0] C_H_LAST     = 11'(C_H_TOTAL - 1);
    localparam logic [10:0] C_V_LAST     = 11'(C_V_TOTAL - 1);
    localparam logic [11:0] C_H_SYNC_END = 12'(H_SYNC);
    localparam logic [11:0] C_V_SYNC_END = 12'(V_SYNC);
    localparam logic [11:0] C_H_ACT_BEG  = 12'(H_SYNC + H_BP);
    localparam logic [11:0] C_H_ACT_END  = 12'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [11:0] C_V_ACT_BEG  = 12'(V_SYNC + V_BP);
    localparam logic [11:0] C_V_ACT_END  = 12'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [10:0] C_X_OFS      = 11'(H_SYNC + H_BP);
    localparam logic [10:0] C_Y_OFS      = 11'(V_SYNC + V_BP);

    // Decode of the counter origin (0,0), used when RUN is entered.
    localparam logic C_HS_ZERO = (H_SYNC == 0) ? 1'b1 : 1'b0;
    localparam logic C_VS_ZERO = (V_SYNC == 0) ? 1'b1 : 1'b0;
    localparam logic C_DE_ZERO = ((H_SYNC + H_BP) == 0) && (H_ACTIVE > 0) &&
                                 ((V_SYNC + V_BP) == 0) && (V_ACTIVE > 0);

    // Delay counter only needs to hold PWR_DELAY-1.
    localparam int                 C_DLY_W    = (PWR_DELAY > 1) ? $clog2(PWR_DELAY) : 1;
    localparam logic [C_DLY_W-1:0] C_DLY_LOAD = C_DLY_W'(PWR_DELAY - 1);
    localparam logic [C_DLY_W-1:0] C_DLY_ONE  = C_DLY_W'(1);

    localparam logic [15:0] C_DIV_RESET = 16'd4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_POWER_UP   = 3'd2,
        ST_RUN        = 3'd3,
        ST_POWER_DOWN = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t               r_state;
    logic                 r_pclk_q;
    logic [10:0]          r_h_cnt;
    logic [10:0]          r_v_cnt;
    logic [C_DLY_W-1:0]   r_dly;
    logic                 r_pd_done;     // POWER_DOWN: last frame finished
    logic                 r_gen_rst;
    logic                 r_disp_on;
    logic                 r_hsync;
    logic                 r_vsync;
    logic                 r_de;
    logic [10:0]          r_x;
    logic [10:0]          r_y;
    logic                 r_frame_start;
    logic                 r_lock_err;
    logic [15:0]          r_clock_divide;
    logic [15:0]          r_div_val;
    logic                 r_div_pend;

    // ------------------------------------------------------------------------
    // Combinational next-count and decode
    // ------------------------------------------------------------------------
    logic        w_tick;
    logic        w_counting;
    logic        w_lock_lost;
    logic        w_h_wrap;
    logic        w_frame_end;
    logic [10:0] w_h_step;
    logic [10:0] w_v_step;
    logic [11:0] w_h_ext;
    logic [11:0] w_v_ext;
    logic        w_hs_step;
    logic        w_vs_step;
    logic        w_de_step;
    logic [10:0] w_x_step;
    logic [10:0] w_y_step;
    logic        w_div_apply;

    assign w_tick      = bus.pclk & ~r_pclk_q;
    // Counters run in RUN and in POWER_DOWN until the last frame completes.
    assign w_counting  = (r_state == ST_RUN) ||
                         ((r_state == ST_POWER_DOWN) && !r_pd_done);
    assign w_lock_lost = !bus.lock && ((r_state == ST_POWER_UP) ||
                                       (r_state == ST_RUN) ||
                                       (r_state == ST_POWER_DOWN));

    always_comb begin
        w_h_wrap    = (r_h_cnt == C_H_LAST);
        w_frame_end = w_h_wrap && (r_v_cnt == C_V_LAST);
        w_h_step    = w_h_wrap ? 11'd0 : (r_h_cnt + 11'd1);
        w_v_step    = r_v_cnt;
        if (w_h_wrap) begin
            w_v_step = (r_v_cnt == C_V_LAST) ? 11'd0 : (r_v_cnt + 11'd1);
        end
        // Outputs are decoded from the post-update counters so that they
        // change on the same edge as the counters.
        w_h_ext   = {1'b0, w_h_step};
        w_v_ext   = {1'b0, w_v_step};
        w_hs_step = !(w_h_ext < C_H_SYNC_END);
        w_vs_step = !(w_v_ext < C_V_SYNC_END);
        w_de_step = (w_h_ext >= C_H_ACT_BEG) && (w_h_ext < C_H_ACT_END) &&
                    (w_v_ext >= C_V_ACT_BEG) && (w_v_ext < C_V_ACT_END);
        w_x_step  = w_h_step - C_X_OFS;
        w_y_step  = w_v_step - C_Y_OFS;
    end

    // While the panel is being scanned a new divide only lands on the tick
    // that closes a frame, so the panel never sees a mid-frame rate change.
    assign w_div_apply = r_div_pend &&
                         (((r_state != ST_RUN) && (r_state != ST_POWER_DOWN)) ||
                          (w_counting && w_tick && w_frame_end));

    // ------------------------------------------------------------------------
    // Sequencer, counters and registered timing outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_pclk_q      <= 1'b0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_dly         <= '0;
            r_pd_done     <= 1'b0;
            r_gen_rst     <= 1'b1;
            r_disp_on     <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
            r_lock_err    <= 1'b0;
        end else begin
            r_pclk_q      <= bus.pclk;
            r_frame_start <= 1'b0;

            if (w_lock_lost) begin
                // Generator unlocked under a live panel: blank and restart.
                r_state   <= ST_WAIT_LOCK;
                r_lock_err <= 1'b1;
                r_h_cnt   <= '0;
                r_v_cnt   <= '0;
                r_dly     <= '0;
                r_pd_done <= 1'b0;
                r_gen_rst <= 1'b0;
                r_disp_on <= 1'b0;
                r_hsync   <= 1'b1;
                r_vsync   <= 1'b1;
                r_de      <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_gen_rst <= 1'b1;
                        r_disp_on <= 1'b0;
                        if (bus.enable) begin
                            r_state    <= ST_WAIT_LOCK;
                            r_gen_rst  <= 1'b0;
                            r_lock_err <= 1'b0;
                        end
                    end

                    ST_WAIT_LOCK: begin
                        if (bus.lock) begin
                            r_state   <= ST_POWER_UP;
                            r_dly     <= C_DLY_LOAD;
                            r_disp_on <= 1'b1;
                            r_pd_done <= 1'b0;
                        end else if (!bus.enable) begin
                            r_state   <= ST_IDLE;
                            r_gen_rst <= 1'b1;
                        end
                    end

                    ST_POWER_UP: begin
                        if (r_dly == '0) begin
                            r_state       <= ST_RUN;
                            r_h_cnt       <= '0;
                            r_v_cnt       <= '0;
                            r_hsync       <= C_HS_ZERO;
                            r_vsync       <= C_VS_ZERO;
                            r_de          <= C_DE_ZERO;
                            r_x           <= C_DE_ZERO ? 11'd0 : r_x;
                            r_y           <= C_DE_ZERO ? 11'd0 : r_y;
                            r_frame_start <= 1'b1;
                        end else begin
                            r_dly <= r_dly - C_DLY_ONE;
                        end
                    end

                    ST_RUN, ST_POWER_DOWN: begin
                        if ((r_state == ST_RUN) && !bus.enable) begin
                            r_state <= ST_POWER_DOWN;
                        end

                        if (w_counting && w_tick) begin
                            if ((r_state == ST_POWER_DOWN) && w_frame_end) begin
                                // Last frame done: park counters, blank, and
                                // start the panel power-off delay.
                                r_pd_done <= 1'b1;
                                r_h_cnt   <= '0;
                                r_v_cnt   <= '0;
                                r_hsync   <= 1'b1;
                                r_vsync   <= 1'b1;
                                r_de      <= 1'b0;
                                r_disp_on <= 1'b0;
                                r_dly     <= C_DLY_LOAD;
                            end else begin
                                r_h_cnt       <= w_h_step;
                                r_v_cnt       <= w_v_step;
                                r_hsync       <= w_hs_step;
                                r_vsync       <= w_vs_step;
                                r_de          <= w_de_step;
                                r_frame_start <= w_frame_end;
                                if (w_de_step) begin
                                    r_x <= w_x_step;
                                    r_y <= w_y_step;
                                end
                            end
                        end

                        if ((r_state == ST_POWER_DOWN) && r_pd_done) begin
                            if (r_dly == '0) begin
                                r_state   <= ST_IDLE;
                                r_gen_rst <= 1'b1;
                                r_pd_done <= 1'b0;
                            end else begin
                                r_dly <= r_dly - C_DLY_ONE;
                            end
                        end
                    end

                    default: begin
                        r_state   <= ST_IDLE;
                        r_gen_rst <= 1'b1;
                        r_disp_on <= 1'b0;
                        r_hsync   <= 1'b1;
                        r_vsync   <= 1'b1;
                        r_de      <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pixel-clock divide: pending register plus frame-aligned transfer.
    // A write landing on the transfer edge stays pending (newest value wins).
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clock_divide <= C_DIV_RESET;
            r_div_val      <= '0;
            r_div_pend     <= 1'b0;
        end else begin
            if (w_div_apply) begin
                r_clock_divide <= r_div_val;
            end
            if (bus.div_wr) begin
                r_div_val  <= bus.div_in;
                r_div_pend <= 1'b1;
            end else if (w_div_apply) begin
                r_div_pend <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.gen_rst      = r_gen_rst;
    assign bus.clock_divide = r_clock_divide;
    assign bus.disp_on      = r_disp_on;
    assign bus.hsync        = r_hsync;
    assign bus.vsync        = r_vsync;
    assign bus.de           = r_de;
    assign bus.x            = r_x;
    assign bus.y            = r_y;
    assign bus.frame_start  = r_frame_start;
    assign bus.lock_err     = r_lock_err;

endmodule
`default_nettype wire

// File: doc/tft_timing_ctrl.md
TFT_TIMING_CTRL -- requirements
Module: tft_timing_ctrl

Interface
REQ-001 Parameters, one per line:
- H_SYNC 41: hsync width, pixel clocks.
- H_BP 2: horizontal back porch.
- H_ACTIVE 480: active pixels per line.
- H_FP 2: horizontal front porch.
- V_SYNC 10: vsync width, lines.
- V_BP 2: vertical back porch.
- V_ACTIVE 272: active lines.
- V_FP 2: vertical front porch.
- PWR_DELAY 1000: power sequencing delay, clk cycles, minimum 1.
REQ-002 Derived totals: H_TOTAL=H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL=V_SYNC+V_BP+V_ACTIVE+V_FP. Counters are 11 bits wide, so H_TOTAL and V_TOTAL SHALL each be ≤2048.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk  in  1  system clock; already decided.
- rst  in  1  reset, synchronous, active-high; already decided.
- enable  in  1  display run request.
- div_in  in  16  requested pixel-clock divide value.
- div_wr  in  1  one-cycle strobe that captures div_in.
- pclk  in  1  pixel clock from the generator, synchronous to clk.
- lock  in  1  generator locked.
- gen_rst  out  1  reset to the pixel-clock generator.
- clock_divide  out  16  divide value driven to the generator.
- disp_on  out  1  panel power/display enable.
- hsync  out  1  active-low horizontal sync.
- vsync  out  1  active-low vertical sync.
- de  out  1  data enable.
- x  out  11  active pixel column.
- y  out  11  active line.
- frame_start  out  1  one-clk pulse.
- lock_err  out  1  sticky lock-loss flag.

Function
REQ-004 The block SHALL register pclk into pclk_q each clk; tick SHALL equal pclk & ~pclk_q. Counters SHALL advance only on clk edges where tick=1.
REQ-005 FSM states SHALL be IDLE, WAIT_LOCK, POWER_UP, RUN, POWER_DOWN.
REQ-006 IDLE: gen_rst=1, disp_on=0. When enable=1, the FSM SHALL go to WAIT_LOCK and clear lock_err.
REQ-007 WAIT_LOCK: gen_rst=0. When lock=1, the FSM SHALL go to POWER_UP and load the delay counter with PWR_DELAY-1. When enable=0, the FSM SHALL return to IDLE.
REQ-008 POWER_UP: disp_on=1, and the delay counter decrements each clk. At count 0 the FSM SHALL go to RUN with h_cnt=v_cnt=0.
REQ-009 RUN horizontal counting: on each tick, h_cnt increments; it wraps at H_TOTAL-1 to 0.
REQ-010 RUN vertical counting: v_cnt increments on each h_cnt wrap and itself wraps at V_TOTAL-1 to 0.
REQ-011 Sync decode, evaluated from the post-update counters:
- hsync=0 iff h_cnt<H_SYNC.
- vsync=0 iff v_cnt<V_SYNC.
REQ-012 Active decode: de=1 iff h_cnt is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v_cnt is in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
REQ-013 When de=1: x=h_cnt-(H_SYNC+H_BP) and y=v_cnt-(V_SYNC+V_BP). When de=0, x and y SHALL hold their last value.
REQ-014 hsync, vsync, de, x and y SHALL be registered and change exactly one clk after the edge where tick=1, i.e. together with the counters.
REQ-015 frame_start SHALL pulse high for exactly one clk when the counters become h_cnt=0, v_cnt=0, including entry into RUN.
REQ-016 Divide capture: div_wr SHALL latch div_in into a pending register and set div_pend. A div_wr while div_pend=1 SHALL overwrite the pending value (last write wins).
REQ-017 Divide apply: in any state other than RUN and POWER_DOWN, the pending value SHALL transfer to clock_divide on the next clk. In RUN or POWER_DOWN, it SHALL transfer only on the tick where both counters wrap (frame end). div_pend SHALL clear on transfer.
REQ-018 div_wr in the same cycle as a transfer SHALL win: its value stays pending and div_pend stays 1.
REQ-019 RUN, enable=0: the FSM SHALL go to POWER_DOWN. Counting SHALL continue until the frame-end tick; then counting stops, outputs go inactive, disp_on=0, and the delay counter loads PWR_DELAY-1. At count 0 the FSM SHALL go to IDLE.
REQ-020 Lock loss: lock=0 in POWER_UP, RUN or POWER_DOWN SHALL set lock_err=1, clear the counters, drive outputs inactive and disp_on=0, and send the FSM to WAIT_LOCK. This takes priority over the enable and delay transitions.
REQ-021 In all states except RUN and POWER_DOWN-before-frame-end, outputs SHALL be inactive: hsync=1, vsync=1, de=0.

Reset
REQ-022 rst=1 SHALL force, on the next clk edge:
- FSM to IDLE.
- gen_rst=1, disp_on=0.
- hsync=1, vsync=1, de=0.
- x=0, y=0, frame_start=0, lock_err=0.
- clock_divide=16'd4, div_pend=0.
- counters, pclk_q and delay counter to 0.
REQ-023 rst asserted mid-frame SHALL abort with no completion of the frame or power-down delay.

Verification
Bench parameters for REQ-024 to REQ-028: H_SYNC=2, H_BP=1, H_ACTIVE=4, H_FP=1, V_SYNC=1, V_BP=1, V_ACTIVE=2, V_FP=1, PWR_DELAY=3. These give H_TOTAL=8 and V_TOTAL=5.
REQ-024 Bring-up: release rst, enable=1, lock=1 → gen_rst=0 in WAIT_LOCK; disp_on=1 for 3 clks before RUN; frame_start pulses once at RUN entry.
REQ-025 Timing: a pclk model toggling every 2 clks runs 2 frames → 40 ticks per frame. Per line: hsync low for ticks 0-1, de high for ticks 3-6 with x=0..3. y=0..1 on lines 2-3; vsync low on line 0 only.
REQ-026 Divide: div_wr with div_in=9 mid-frame in RUN → clock_divide stays 4 until the frame-end tick, then becomes 9. A second div_wr=7 before frame end → 7 is applied, not 9.
REQ-027 Power-down: enable=0 at v_cnt=2 → frame completes; then disp_on=0, 3 clks later IDLE with gen_rst=1.
REQ-028 Lock loss: lock=0 during RUN → lock_err=1, de=0, disp_on=0, state WAIT_LOCK. Restoring lock=1 → POWER_UP, then a new frame_start. lock_err stays 1 until the next IDLE→WAIT_LOCK transition.
